// File: rtl/sdram_wb_bridge.sv
// Wishbone B4 classic slave onto the 16-bit SDRAM controller host port.
// Each bus word is split into WB_DW/16 lane transactions; partial lanes use read-modify-write.
module sdram_wb_bridge #(
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_DW/8-1:0] wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [31:0]        ctl_addr_o,
  output logic [15:0]        ctl_wr_data_o,
  output logic               ctl_wr_enable_o,
  output logic               ctl_rd_enable_o,
  input  logic [15:0]        ctl_rd_data_i,
  input  logic               ctl_rd_ready_i,
  input  logic               ctl_busy_i
);

  localparam int N  = WB_DW / 16;
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][15:0] lanes_t;
  typedef logic [N-1:0][1:0]  sels_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_RMW_RD_ISSUE, S_RMW_RD_WAIT,
    S_WR_ISSUE, S_WR_WAIT, S_ACK, S_ERR
  } state_t;

  state_t          r_state, w_state_next;
  logic [LW-1:0]   r_lane, w_lane_next;
  logic [31:0]     r_cnt;
  logic [31:0]     r_base;
  logic            r_we;
  sels_t           r_sel;
  lanes_t          r_wdat;
  lanes_t          r_rdat;

  sels_t           w_sel_in;
  logic [31:0]     w_base;
  logic            w_req;
  logic            w_tmo;
  logic            w_counting;
  logic            w_rd_en, w_wr_en;
  logic [LW:0]     w_first, w_nxt;
  logic [15:0]     w_merged;

  // First lane at or above 'from' with any byte selected; MSB set means none left.
  function automatic logic [LW:0] f_next_wr(input sels_t sel, input int from);
    logic [LW:0] res;
    res = {1'b1, {LW{1'b0}}};
    for (int k = N - 1; k >= 0; k--)
      if (k >= from && sel[k] != 2'b00) res = {1'b0, LW'(k)};
    return res;
  endfunction

  function automatic state_t f_path(input logic [1:0] sel);
    return (sel == 2'b11) ? S_WR_ISSUE : S_RMW_RD_ISSUE;
  endfunction

  assign w_sel_in   = wb_sel_i;
  assign w_base     = (wb_adr_i >> 1) & ~(32'(N) - 32'd1);
  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_first    = f_next_wr(w_sel_in, 0);
  assign w_nxt      = f_next_wr(r_sel, int'(r_lane) + 1);
  assign w_tmo      = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));
  assign w_counting = (r_state inside {S_RD_ISSUE, S_RD_WAIT, S_RMW_RD_ISSUE,
                                       S_RMW_RD_WAIT, S_WR_ISSUE, S_WR_WAIT});
  assign w_merged   = {r_sel[r_lane][1] ? r_wdat[r_lane][15:8] : ctl_rd_data_i[15:8],
                       r_sel[r_lane][0] ? r_wdat[r_lane][7:0]  : ctl_rd_data_i[7:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_lane_next  = r_lane;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_req) begin
        w_lane_next = '0;
        if (!wb_we_i)     w_state_next = S_RD_ISSUE;
        else if (w_first[LW]) w_state_next = S_ACK;
        else begin
          w_lane_next  = w_first[LW-1:0];
          w_state_next = f_path(w_sel_in[w_first[LW-1:0]]);
        end
      end
      S_RD_ISSUE, S_RMW_RD_ISSUE: begin
        if (!wb_cyc_i) w_state_next = S_IDLE;
        else if (!ctl_busy_i) begin
          w_rd_en      = 1'b1;
          w_state_next = (r_state == S_RD_ISSUE) ? S_RD_WAIT : S_RMW_RD_WAIT;
        end else if (w_tmo) w_state_next = S_ERR;
      end
      S_RD_WAIT: begin
        if (ctl_rd_ready_i) begin
          if (!wb_cyc_i)                  w_state_next = S_IDLE;
          else if (r_lane == LW'(N - 1))  w_state_next = S_ACK;
          else begin
            w_lane_next  = r_lane + 1'b1;
            w_state_next = S_RD_ISSUE;
          end
        end else if (w_tmo) w_state_next = S_ERR;
      end
      S_RMW_RD_WAIT: begin
        if (ctl_rd_ready_i) w_state_next = wb_cyc_i ? S_WR_ISSUE : S_IDLE;
        else if (w_tmo)     w_state_next = S_ERR;
      end
      S_WR_ISSUE: begin
        if (!wb_cyc_i) w_state_next = S_IDLE;
        else if (!ctl_busy_i) begin
          w_wr_en      = 1'b1;
          w_state_next = S_WR_WAIT;
        end else if (w_tmo) w_state_next = S_ERR;
      end
      S_WR_WAIT: begin
        // Busy in the cycle right after the enable may not yet reflect the new write.
        if (r_cnt != 32'd0 && !ctl_busy_i) begin
          if (!wb_cyc_i)      w_state_next = S_IDLE;
          else if (w_nxt[LW]) w_state_next = S_ACK;
          else begin
            w_lane_next  = w_nxt[LW-1:0];
            w_state_next = f_path(r_sel[w_nxt[LW-1:0]]);
          end
        end else if (w_tmo) w_state_next = S_ERR;
      end
      S_ACK, S_ERR: w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_next;
      r_lane  <= w_lane_next;
      r_cnt   <= (w_state_next != r_state || !w_counting) ? '0 : r_cnt + 32'd1;
      if (r_state == S_IDLE && w_req) begin
        r_we   <= wb_we_i;
        r_sel  <= w_sel_in;
        r_wdat <= wb_dat_i;
        r_rdat <= '0;
        r_base <= w_base;
      end
      if (r_state == S_RD_WAIT && ctl_rd_ready_i)     r_rdat[r_lane] <= ctl_rd_data_i;
      if (r_state == S_RMW_RD_WAIT && ctl_rd_ready_i) r_wdat[r_lane] <= w_merged;
    end
  end

  assign ctl_addr_o      = r_base + 32'(r_lane);
  assign ctl_wr_data_o   = r_wdat[r_lane];
  assign ctl_rd_enable_o = w_rd_en;
  assign ctl_wr_enable_o = w_wr_en;
  assign wb_ack_o        = (r_state == S_ACK);
  assign wb_err_o        = (r_state == S_ERR);
  assign wb_dat_o        = (r_state == S_ACK && !r_we) ? r_rdat : '0;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench: a 32-bit and a 64-bit bridge share one behavioural SDRAM controller model.
module tb_sdram_wb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc32 = 1'b0, cyc64 = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat32 = '0;
  logic [3:0]  sel32 = '0;
  logic [63:0] dat64 = '0;
  logic [7:0]  sel64 = '0;
  logic        use64 = 1'b0;

  logic [31:0] dat_o32;
  logic [63:0] dat_o64;
  logic        ack32, err32, ack64, err64;
  logic [31:0] addr32, addr64;
  logic [15:0] wd32, wd64;
  logic        we32, we64, re32, re64;

  logic [15:0] ctl_rd_data_i = '0;
  logic        ctl_rd_ready_i = 1'b0;
  logic        ctl_busy_i = 1'b0;

  always #5 clk_i = ~clk_i;

  sdram_wb_bridge #(.WB_DW(32), .TIMEOUT(16)) u_dut32 (
    .clk_i(clk_i), .rst_n(rst_n), .wb_cyc_i(cyc32), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel32), .wb_adr_i(adr), .wb_dat_i(dat32), .wb_dat_o(dat_o32),
    .wb_ack_o(ack32), .wb_err_o(err32), .ctl_addr_o(addr32), .ctl_wr_data_o(wd32),
    .ctl_wr_enable_o(we32), .ctl_rd_enable_o(re32), .ctl_rd_data_i(ctl_rd_data_i),
    .ctl_rd_ready_i(ctl_rd_ready_i), .ctl_busy_i(ctl_busy_i));

  sdram_wb_bridge #(.WB_DW(64), .TIMEOUT(16)) u_dut64 (
    .clk_i(clk_i), .rst_n(rst_n), .wb_cyc_i(cyc64), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel64), .wb_adr_i(adr), .wb_dat_i(dat64), .wb_dat_o(dat_o64),
    .wb_ack_o(ack64), .wb_err_o(err64), .ctl_addr_o(addr64), .ctl_wr_data_o(wd64),
    .ctl_wr_enable_o(we64), .ctl_rd_enable_o(re64), .ctl_rd_data_i(ctl_rd_data_i),
    .ctl_rd_ready_i(ctl_rd_ready_i), .ctl_busy_i(ctl_busy_i));

  wire [31:0] m_addr  = use64 ? addr64 : addr32;
  wire [15:0] m_wdata = use64 ? wd64 : wd32;
  wire        m_wr_en = use64 ? we64 : we32;
  wire        m_rd_en = use64 ? re64 : re32;

  // Controller model: read latency 'lat' (enable cycle c -> rd_ready in cycle c+lat),
  // busy high for busy_b-1 cycles after each write enable.
  logic [15:0] mem [0:63];
  int          cyc_n = 0;
  int          lat = 4, busy_b = 3;
  bit          stall = 0;
  bit          rd_pend = 0;
  int          rd_due = 0, busy_left = 0;
  logic [31:0] rd_a = '0;
  int          n_rd = 0, n_wr = 0;
  logic [31:0] rd_log [0:15];
  int          rd_cyc_log [0:15];
  logic [31:0] wlog_a [0:15];
  logic [15:0] wlog_d [0:15];

  always @(posedge clk_i) begin
    if (m_rd_en) begin
      rd_pend = 1; rd_due = cyc_n + lat; rd_a = m_addr;
      if (n_rd < 16) begin rd_log[n_rd] = m_addr; rd_cyc_log[n_rd] = cyc_n; end
      n_rd++;
    end
    if (m_wr_en) begin
      mem[m_addr[5:0]] = m_wdata;
      if (n_wr < 16) begin wlog_a[n_wr] = m_addr; wlog_d[n_wr] = m_wdata; end
      n_wr++;
      busy_left = busy_b - 1;
    end
    cyc_n++;
    if (rd_pend && !stall && cyc_n == rd_due) begin
      ctl_rd_ready_i <= 1'b1;
      ctl_rd_data_i  <= mem[rd_a[5:0]];
      rd_pend = 0;
    end else begin
      ctl_rd_ready_i <= 1'b0;
      ctl_rd_data_i  <= '0;
    end
    if (busy_left > 0) begin ctl_busy_i <= 1'b1; busy_left--; end
    else ctl_busy_i <= 1'b0;
  end

  wire w_ack = use64 ? ack64 : ack32;
  wire w_err = use64 ? err64 : err32;

  int n_checks = 0;
  int n_errors = 0;

  task automatic clear_logs();
    n_rd = 0; n_wr = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  // Drives one bus access and waits (bounded) for ack or err; t_acc is the acceptance cycle.
  task automatic access(input bit wide, input bit wr, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] s,
                        output bit ack, output bit err, output logic [63:0] rdat,
                        output int t_acc, output int t_done);
    @(negedge clk_i);
    use64 = wide; stb = 1'b1; we = wr; adr = a;
    dat32 = d[31:0]; sel32 = s[3:0]; dat64 = d; sel64 = s;
    if (wide) cyc64 = 1'b1; else cyc32 = 1'b1;
    t_acc = cyc_n; ack = 0; err = 0; rdat = '0; t_done = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (w_ack || w_err) begin
        ack = w_ack; err = w_err; t_done = cyc_n;
        rdat = wide ? dat_o64 : {32'h0, dat_o32};
        break;
      end
    end
    cyc32 = 1'b0; cyc64 = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ack32, err32, re32, we32, ack64, err64} !== 6'b0 || dat_o32 !== '0 || addr32 !== '0) begin
      $display("FAIL reset_outputs: ack=%b err=%b dat=%h addr=%h, expected all 0", ack32, err32, dat_o32, addr32);
      n_errors++;
    end
  endtask

  task automatic test_read32();
    bit ack, err; logic [63:0] rd; int ta, td;
    clear_logs();
    mem[8] = 16'hBEEF; mem[9] = 16'hDEAD;
    access(0, 0, 32'h10, 64'h0, 8'h0F, ack, err, rd, ta, td);
    n_checks++;
    if (!(ack === 1'b1 && err === 1'b0)) begin
      $display("FAIL read32_ack: ack=%b err=%b, expected ack=1 err=0", ack, err); n_errors++;
    end
    n_checks++;
    if (rd[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL read32_data: got %h, expected DEADBEEF", rd[31:0]); n_errors++;
    end
    // Acceptance cycle counts as cycle 1: 1 + 2*(1+4) + 1 = 12, i.e. ack 11 cycles later.
    n_checks++;
    if (td - ta !== 11) begin
      $display("FAIL read32_latency: ack %0d cycles after acceptance, expected 11", td - ta); n_errors++;
    end
    n_checks++;
    if (n_rd !== 2 || rd_log[0] !== 32'd8 || rd_log[1] !== 32'd9 || n_wr !== 0) begin
      $display("FAIL read32_addr: n_rd=%0d a0=%0d a1=%0d n_wr=%0d, expected 2,8,9,0", n_rd, rd_log[0], rd_log[1], n_wr);
      n_errors++;
    end
    @(negedge clk_i);
    n_checks++;
    if (ack32 !== 1'b0 || dat_o32 !== 32'h0) begin
      $display("FAIL read32_ack_pulse: ack=%b dat=%h one cycle later, expected 0/0", ack32, dat_o32); n_errors++;
    end
  endtask

  task automatic test_write_full();
    bit ack, err; logic [63:0] rd; int ta, td;
    clear_logs();
    access(0, 1, 32'h20, 64'h12345678, 8'h0F, ack, err, rd, ta, td);
    n_checks++;
    if (!(ack === 1'b1 && err === 1'b0) || rd !== 64'h0) begin
      $display("FAIL write_full_ack: ack=%b err=%b dat=%h, expected 1,0,0", ack, err, rd); n_errors++;
    end
    n_checks++;
    if (n_wr !== 2 || wlog_a[0] !== 32'd16 || wlog_d[0] !== 16'h5678 ||
        wlog_a[1] !== 32'd17 || wlog_d[1] !== 16'h1234 || n_rd !== 0) begin
      $display("FAIL write_full_ops: n_wr=%0d %0d:%h %0d:%h n_rd=%0d, expected 2 16:5678 17:1234 0",
               n_wr, wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1], n_rd);
      n_errors++;
    end
  endtask

  task automatic test_write_rmw();
    bit ack, err; logic [63:0] rd; int ta, td;
    clear_logs();
    mem[16] = 16'h5555; mem[17] = 16'h1234;
    access(0, 1, 32'h20, 64'h00AB0000, 8'h04, ack, err, rd, ta, td);
    n_checks++;
    if (!(ack === 1'b1 && err === 1'b0)) begin
      $display("FAIL rmw_ack: ack=%b err=%b, expected 1,0", ack, err); n_errors++;
    end
    n_checks++;
    if (n_rd !== 1 || rd_log[0] !== 32'd17 || n_wr !== 1 || wlog_a[0] !== 32'd17 || wlog_d[0] !== 16'h12AB) begin
      $display("FAIL rmw_ops: n_rd=%0d ra=%0d n_wr=%0d %0d:%h, expected 1 17 1 17:12ab",
               n_rd, rd_log[0], n_wr, wlog_a[0], wlog_d[0]);
      n_errors++;
    end
    n_checks++;
    if (mem[16] !== 16'h5555) begin
      $display("FAIL rmw_untouched: word16=%h, expected 5555", mem[16]); n_errors++;
    end
  endtask

  task automatic test_write_nosel();
    bit ack, err; logic [63:0] rd; int ta, td;
    clear_logs();
    access(0, 1, 32'h20, 64'hFFFFFFFF, 8'h00, ack, err, rd, ta, td);
    n_checks++;
    if (ack !== 1'b1 || td - ta !== 1 || n_wr !== 0 || n_rd !== 0) begin
      $display("FAIL nosel_write: ack=%b delay=%0d n_wr=%0d n_rd=%0d, expected 1,1,0,0", ack, td - ta, n_wr, n_rd);
      n_errors++;
    end
  endtask

  task automatic test_timeout();
    bit ack, err; logic [63:0] rd; int ta, td;
    clear_logs();
    stall = 1;
    access(0, 0, 32'h10, 64'h0, 8'h0F, ack, err, rd, ta, td);
    n_checks++;
    if (!(err === 1'b1 && ack === 1'b0) || rd !== 64'h0) begin
      $display("FAIL timeout_err: ack=%b err=%b dat=%h, expected 0,1,0", ack, err, rd); n_errors++;
    end
    n_checks++;
    if (n_rd !== 1 || td - rd_cyc_log[0] !== 17) begin
      $display("FAIL timeout_delay: n_rd=%0d err %0d cycles after enable, expected 1 and 17", n_rd, td - rd_cyc_log[0]);
      n_errors++;
    end
    @(negedge clk_i);
    stall = 0; rd_pend = 0;
    clear_logs();
    mem[8] = 16'h0F0F; mem[9] = 16'hA5A5;
    access(0, 0, 32'h10, 64'h0, 8'h0F, ack, err, rd, ta, td);
    n_checks++;
    if (ack !== 1'b1 || err !== 1'b0 || rd[31:0] !== 32'hA5A50F0F) begin
      $display("FAIL timeout_recover: ack=%b err=%b dat=%h, expected 1,0,a5a50f0f", ack, err, rd[31:0]);
      n_errors++;
    end
  endtask

  task automatic test_reset_mid();
    bit ack, err; logic [63:0] rd; int ta, td; int seen;
    clear_logs();
    mem[8] = 16'h1111; mem[9] = 16'h2222;
    @(negedge clk_i);
    use64 = 0; cyc32 = 1; stb = 1; we = 0; adr = 32'h10; sel32 = 4'hF;
    for (int i = 0; i < 20 && n_rd == 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ack32, err32, re32, we32} !== 4'b0 || dat_o32 !== '0 || addr32 !== '0 || wd32 !== '0) begin
      $display("FAIL reset_mid_outputs: ack=%b err=%b re=%b we=%b dat=%h addr=%h, expected all 0",
               ack32, err32, re32, we32, dat_o32, addr32);
      n_errors++;
    end
    cyc32 = 0; stb = 0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (ack32 || err32) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL reset_mid_noack: %0d ack/err cycles after reset, expected 0", seen); n_errors++;
    end
    access(0, 0, 32'h10, 64'h0, 8'h0F, ack, err, rd, ta, td);
    n_checks++;
    if (ack !== 1'b1 || rd[31:0] !== 32'h22221111) begin
      $display("FAIL reset_mid_next: ack=%b dat=%h, expected 1,22221111", ack, rd[31:0]); n_errors++;
    end
  endtask

  task automatic test_cyc_drop64();
    bit ack, err; logic [63:0] rd; int ta, td; int seen;
    clear_logs();
    @(negedge clk_i);
    use64 = 1; cyc64 = 1; stb = 1; we = 1; adr = 32'h40;
    dat64 = 64'h4444_3333_2222_1111; sel64 = 8'hFF;
    for (int i = 0; i < 20 && n_wr == 0; i++) @(negedge clk_i);
    cyc64 = 0; stb = 0; we = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (ack64 || err64) seen++;
    end
    n_checks++;
    if (seen !== 0 || n_wr !== 1 || wlog_a[0] !== 32'd32 || wlog_d[0] !== 16'h1111 || mem[33] !== 16'h0) begin
      $display("FAIL cyc_drop: ackerr=%0d n_wr=%0d %0d:%h w33=%h, expected 0 1 32:1111 0",
               seen, n_wr, wlog_a[0], wlog_d[0], mem[33]);
      n_errors++;
    end
    access(1, 0, 32'h40, 64'h0, 8'hFF, ack, err, rd, ta, td);
    n_checks++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 64'h0000_0000_0000_1111 || td - ta !== 21) begin
      $display("FAIL cyc_drop_idle: ack=%b err=%b dat=%h delay=%0d, expected 1 0 1111 21", ack, err, rd, td - ta);
      n_errors++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk_i);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk_i);
    test_read32();
    test_write_full();
    test_write_rmw();
    test_write_nosel();
    test_timeout();
    test_reset_mid();
    test_cyc_drop64();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
